// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Purpose : common word type, instruction-cache address split and the
//           instruction-cache controller state encoding, shared by the
//           cache RTL and the dual-core bench monitors.
// Contents: word_t, ITAG_W, IIDX_W, icachef_t {tag, idx, bytoff},
//           icache_state_t {IDLE, FETCH}.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Instruction-cache bus bundle.
// Purpose : groups the datapath fetch port, the memory-controller fill port
//           and the statistics counters of one icache_direct instance.
// Ports   : imemREN/imemaddr/iflush -> cache, imemload/ihit <- cache,
//           iREN/iaddr <- cache, iload/iwait -> cache,
//           hit_count/miss_count <- cache.
// Modports: slave  - the cache itself.
//           master - the environment (datapath + memory controller).
interface icache_direct_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    word_t imemload;
    logic  ihit;
    logic  iflush;
    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  iwait;
    word_t hit_count;
    word_t miss_count;

    modport slave (
        input  imemREN, imemaddr, iflush, iload, iwait,
        output imemload, ihit, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, iflush, iload, iwait,
        input  imemload, ihit, iREN, iaddr, hit_count, miss_count
    );

endinterface

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage for the instruction cache.
// Purpose : NFRAMES frames of {valid, tag, data}; one combinational read
//           port, one synchronous write port, synchronous flush-all.
// Ports   : CLK, RST        - clock / sync active-high reset (clears valid)
//           flush_i         - clear every valid bit at the edge
//           rd_idx_i        - read index; rd_valid_o/rd_tag_o/rd_data_o
//           wr_en_i, wr_idx_i, wr_tag_i, wr_data_i - install a valid frame
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output word_t            rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  word_t            wr_data_i
);

    logic [NFRAMES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [NFRAMES];
    word_t              data_q [NFRAMES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Flush wins over a write in the same cycle; the controller never
    // requests both, but the array stays safe if it did.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless while the valid bit is clear,
    // so they carry no reset.
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Per-CPU direct-mapped instruction cache.
// Purpose : serves instruction fetches combinationally on a hit; on a miss
//           issues a single-word fill to the memory arbiter, installs the
//           word and lets the retried fetch hit.
// Ports   : CLK, RST - clock / sync active-high reset
//           bus      - icache_direct_if.slave (fetch port, fill port,
//                      hit/miss counters)
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic              CLK,
    input  logic              RST,
    icache_direct_if.slave    bus
);

    icache_state_t state_q, state_d;
    word_t         miss_addr_q, miss_addr_d;
    logic          drop_q, drop_d;
    word_t         hit_count_q, hit_count_d;
    word_t         miss_count_q, miss_count_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;

    logic hit;
    logic miss;
    logic wr_en;

    assign req_tag  = bus.imemaddr[31:IDX_W+2];
    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];

    icache_frame_array #(
        .NFRAMES (NFRAMES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_frames (
        .CLK        (CLK),
        .RST        (RST),
        .flush_i    (bus.iflush),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (fill_idx),
        .wr_tag_i   (fill_tag),
        .wr_data_i  (bus.iload)
    );

    // Hits are only served in IDLE; a flush forces the hit off in the flush
    // cycle itself since the frame is being invalidated at this edge.
    assign hit  = (state_q == IDLE) && bus.imemREN && rd_valid &&
                  (rd_tag == req_tag) && !bus.iflush;
    assign miss = (state_q == IDLE) && bus.imemREN && !hit;

    assign bus.ihit       = hit;
    assign bus.imemload   = hit ? rd_data : '0;
    assign bus.iREN       = (state_q == FETCH);
    assign bus.iaddr      = miss_addr_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        drop_d       = drop_q;
        wr_en        = 1'b0;
        hit_count_d  = hit_count_q + (hit ? 32'd1 : 32'd0);
        miss_count_d = miss_count_q + (miss ? 32'd1 : 32'd0);

        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    miss_addr_d = {bus.imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (!bus.iwait) begin
                    // A flush seen at any point of this fill (earlier via
                    // drop_q, or right now) means the word is stale.
                    wr_en   = !(drop_q || bus.iflush);
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.iflush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            drop_q       <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            drop_q       <= drop_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Per-CPU direct-mapped instruction cache. Sits directly upstream of the memory controller: the datapath side serves instruction fetches, and the memory side drives that CPU's iREN/iaddr slot and consumes iload/iwait.
- One instance per CPU (two in the dual-core build).
- Hits complete combinationally in the fetch cycle. A miss issues a single-word fill to the arbiter and then retires as a hit.

Parameters:
- NFRAMES, 16, number of one-word frames (power of 2).
- IDX_W, 4, index width, equal to log2(NFRAMES).
- TAG_W, 26, tag width, equal to 32 - IDX_W - 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] are ignored.
- imemload  out  32  fetched instruction, valid when ihit=1.
- ihit  out  1  fetch satisfied this cycle.
- iflush  in  1  invalidate all frames.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  fill address, word aligned.
- iload  in  32  fill data, valid when iwait=0.
- iwait  in  1  memory controller busy; 0 means the fill word is present this cycle.
- hit_count  out  32  number of hits retired.
- miss_count  out  32  number of misses started.

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2].
- Frame = {valid, tag[TAG_W], data[32]}.
- Reset (RST=1 at a clock edge):
  - All valid bits are cleared; tag and data contents are don't-care.
  - State goes to IDLE; iREN=0, iaddr=0, both counters=0.
  - ihit=0 and imemload=0 follow from valid=0.
  - Reset mid-FETCH abandons the fill, and iREN drops in the following cycle.
- States:
  - IDLE: serve hits; detect misses.
  - FETCH: fill in progress.
  - No other states.
- IDLE:
  - Hit: imemREN and valid[idx] and tag match. Then ihit=1 and imemload=data[idx], same cycle, combinational. hit_count increments at the clock edge.
  - Miss: imemREN with no hit. Then ihit=0, the miss address is latched (word aligned, low 2 bits zeroed), miss_count increments, and the next state is FETCH.
  - When imemREN=0: ihit=0 and imemload=0; no state change.
- FETCH:
  - Registered iREN=1 and iaddr=latched address, held stable until completion.
  - ihit=0 regardless of imemREN.
  - When iwait=0: write frame[latched idx] = {1, latched tag, iload}, then go to IDLE. The retried fetch hits on the next cycle, so miss latency = arbiter latency + 1 cycle.
  - iREN deasserts in the cycle after iwait=0. The arbiter requires iREN low before re-arbitration.
  - A change of imemaddr or imemREN during FETCH does not abort or redirect the fill. The fill completes to the latched address, and a new address is evaluated in IDLE afterwards.
- iflush:
  - In IDLE: all valid bits clear at the edge. ihit is forced to 0 in the flush cycle itself.
  - In FETCH: valid bits clear, a sticky drop flag is set, and the outstanding fill still completes the bus handshake. The returned word is discarded (not written valid). The drop flag clears on return to IDLE.
  - iflush coincident with iwait=0: the word is discarded.
- Counters: free-running 32-bit and wrap at 2^32-1 to 0. A hit and a miss cannot occur in the same cycle.
- iaddr[1:0] is always 0.

Decomposition:
- cpu_types_pkg (shared) holds:
  - word_t (32-bit).
  - icachef_t packed struct {tag, idx, bytoff}.
  - ITAG_W and IIDX_W constants.
  - icache_state_t enum {IDLE, FETCH}, for reuse by the dual-core bench monitors.
- One natural sub-module: icache_frame_array.
  - NFRAMES×(1+TAG_W+32) storage.
  - One combinational read port and one write port.
  - A synchronous flush-all input and reset clear.
- The FSM, latch registers and counters stay in icache_direct.

Test Plan:
- Cold miss: RST, then imemREN=1, imemaddr=0x00000040. Required: iREN=1 and iaddr=0x00000040 the next cycle. Drive iwait=0 with iload=0x2001000A after 3 cycles. Required: ihit=1 and imemload=0x2001000A one cycle later; miss_count=1, hit_count=1.
- Conflict eviction: fill 0x00000040, then fetch 0x00000440 (same idx 0, different tag). Required: miss and refill. Then fetch 0x00000040. Required: miss again; miss_count=3.
- Address change mid-fill: miss on 0x00000080, then switch imemaddr to 0x000000C4 while iwait=1. Required: iaddr stays 0x00000080 until iwait=0; frame 0 gets 0x00000080's word; 0x000000C4 then misses separately.
- Flush during FETCH: miss on 0x00000010, assert iflush for 1 cycle while iwait=1, then iwait=0 with iload=0xDEADBEEF. Required: the handshake completes, and a refetch of 0x00000010 misses (word not installed).
- Reset mid-fill: RST asserted in FETCH. Required: iREN=0 on the next cycle, counters=0, and every previously-filled address misses.
- Byte offset ignored: fill 0x00000100, fetch 0x00000103. Required: ihit=1 with the same data and no new miss.
